// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and default timing constants.
// No logic; imported by the hazard controller and its sub-modules.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } hz_state_t;

  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_MEM_TIMEOUT  = 255;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-high clear.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, jump flush, data-memory wait/timeout.
// Controls are combinational in the cycle the hazard is seen; memory wait freezes the whole pipe.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  ID_REG_RA1,
  input  logic [4:0]  ID_REG_RA2,
  input  logic        ID_UsesRA2,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_REG_WA,
  input  logic        EX_JumpTaken,
  input  logic        DMEM_REQ,
  input  logic        DMEM_READY,
  output logic        PC_WE,
  output logic        IF_ID_WE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        PIPE_HOLD,
  output logic        MEM_ERR,
  output logic [15:0] STALL_CNT
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

  hz_state_t  state_q, state_d;
  hz_state_t  saved_q, saved_d;
  logic [2:0] flush_q, flush_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = DMEM_REQ & ~DMEM_READY;
  assign load_use  = EX_MemRead & (EX_REG_WA != 5'd0) &
                     ((EX_REG_WA == ID_REG_RA1) | (ID_UsesRA2 & (EX_REG_WA == ID_REG_RA2)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_RUN;
      saved_q   <= ST_RUN;
      flush_q   <= '0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      flush_q   <= flush_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    flush_d      = flush_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    PC_WE        = 1'b1;
    IF_ID_WE     = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    PIPE_HOLD    = 1'b0;

    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mem_stall) begin
          // Freeze everything; the flush counter is parked so the flush resumes afterwards.
          PC_WE     = 1'b0;
          IF_ID_WE  = 1'b0;
          PIPE_HOLD = 1'b1;
          saved_d   = state_q;
          wait_d    = '0;
          state_d   = ST_MEM_WAIT;
        end else if (EX_JumpTaken) begin
          IF_ID_FLUSH  = 1'b1;
          ID_EX_BUBBLE = 1'b1;
          flush_d      = FLUSH_LOAD;
          state_d      = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (load_use) begin
          PC_WE        = 1'b0;
          IF_ID_WE     = 1'b0;
          ID_EX_BUBBLE = 1'b1;
        end else if (state_q == ST_FLUSH) begin
          IF_ID_FLUSH = 1'b1;
          flush_d     = (flush_q != 3'd0) ? flush_q - 3'd1 : 3'd0;
          if (flush_q <= 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (DMEM_READY) begin
          wait_d  = '0;
          state_d = saved_q;
        end else begin
          PC_WE     = 1'b0;
          IF_ID_WE  = 1'b0;
          PIPE_HOLD = 1'b1;
          wait_d    = wait_q + 8'd1;
          if (wait_q == TIMEOUT_M1) begin
            state_d   = ST_ERROR;
            mem_err_d = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        PC_WE     = 1'b0;
        IF_ID_WE  = 1'b0;
        PIPE_HOLD = 1'b1;
        mem_err_d = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (RST) begin
      PC_WE        = 1'b0;
      IF_ID_WE     = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
      PIPE_HOLD    = 1'b0;
    end
  end

  assign MEM_ERR = mem_err_q;

  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (~PC_WE),
    .count (STALL_CNT)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes expected controls per cycle,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ID_REG_RA1, ID_REG_RA2, EX_REG_WA;
  logic        ID_UsesRA2, EX_MemRead, EX_JumpTaken, DMEM_REQ, DMEM_READY;
  logic        PC_WE, IF_ID_WE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_HOLD, MEM_ERR;
  logic [15:0] STALL_CNT;

  // {PC_WE, IF_ID_WE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_HOLD}
  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_NORM = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_JMP  = 5'b11110;
  localparam logic [4:0] C_FL   = 5'b11100;
  localparam logic [4:0] C_HOLD = 5'b00001;

  typedef struct {
    int          tag;
    logic [4:0]  ctl;
    logic        err;
    logic [15:0] stall;
    bit          chk_regs;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [4:0]  mon_act;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          step_no = 0;
  logic [15:0] exp_stall = 16'd0;

  hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_REG_RA1   (ID_REG_RA1),
    .ID_REG_RA2   (ID_REG_RA2),
    .ID_UsesRA2   (ID_UsesRA2),
    .EX_MemRead   (EX_MemRead),
    .EX_REG_WA    (EX_REG_WA),
    .EX_JumpTaken (EX_JumpTaken),
    .DMEM_REQ     (DMEM_REQ),
    .DMEM_READY   (DMEM_READY),
    .PC_WE        (PC_WE),
    .IF_ID_WE     (IF_ID_WE),
    .IF_ID_FLUSH  (IF_ID_FLUSH),
    .ID_EX_BUBBLE (ID_EX_BUBBLE),
    .PIPE_HOLD    (PIPE_HOLD),
    .MEM_ERR      (MEM_ERR),
    .STALL_CNT    (STALL_CNT)
  );

  always #5 CLK = ~CLK;

  // One cycle of stimulus plus its expected controls; STALL_CNT expectation is tracked here.
  task automatic step(input logic rst, input logic jmp, input logic req, input logic rdy,
                      input logic mr, input logic [4:0] wa, input logic [4:0] ra1,
                      input logic [4:0] ra2, input logic u2,
                      input logic [4:0] ctl, input logic err);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; EX_JumpTaken = jmp; DMEM_REQ = req; DMEM_READY = rdy;
    EX_MemRead = mr; EX_REG_WA = wa; ID_REG_RA1 = ra1; ID_REG_RA2 = ra2; ID_UsesRA2 = u2;
    e.tag      = step_no;
    e.ctl      = ctl;
    e.err      = err;
    e.stall    = exp_stall;
    e.chk_regs = !rst;
    sb.push_back(e);
    step_no++;
    if (rst) exp_stall = 16'd0;
    else if (!ctl[4] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        mon_e   = sb.pop_front();
        mon_act = {PC_WE, IF_ID_WE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_HOLD};
        n_cmp++;
        if (mon_act !== mon_e.ctl ||
            (mon_e.chk_regs && (MEM_ERR !== mon_e.err || STALL_CNT !== mon_e.stall))) begin
          n_bad++;
          $display("FAIL step%0d: got ctl=%b err=%b stall=%0d, want ctl=%b err=%b stall=%0d",
                   mon_e.tag, mon_act, MEM_ERR, STALL_CNT, mon_e.ctl, mon_e.err, mon_e.stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; EX_JumpTaken = 1'b0; DMEM_REQ = 1'b0; DMEM_READY = 1'b0;
    EX_MemRead = 1'b0; EX_REG_WA = '0; ID_REG_RA1 = '0; ID_REG_RA2 = '0; ID_UsesRA2 = 1'b0;

    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // load-use on RA1, then x0 destination, then RA2 gated by ID_UsesRA2
    step(0, 0,0,0, 1,5,5,0,0, C_LU,   0);
    step(0, 0,0,0, 0,0,5,0,0, C_NORM, 0);
    step(0, 0,0,0, 1,0,0,0,0, C_NORM, 0);
    step(0, 0,0,0, 1,7,1,7,0, C_NORM, 0);
    step(0, 0,0,0, 1,7,1,7,1, C_LU,   0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // jump with one extra flush cycle
    step(0, 1,0,0, 0,0,0,0,0, C_JMP,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_FL,   0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // second jump during FLUSH reloads the counter
    step(0, 1,0,0, 0,0,0,0,0, C_JMP,  0);
    step(0, 1,0,0, 0,0,0,0,0, C_JMP,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_FL,   0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // jump outranks load-use
    step(0, 1,0,0, 1,5,5,0,0, C_JMP,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_FL,   0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // three-cycle memory stall from a fresh STALL_CNT
    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,1, 0,0,0,0,0, C_NORM, 0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // memory stall in FLUSH resumes exactly one flush cycle
    step(0, 1,0,0, 0,0,0,0,0, C_JMP,  0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,1, 0,0,0,0,0, C_NORM, 0);
    step(0, 0,0,0, 0,0,0,0,0, C_FL,   0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // mem_stall + jump + load-use together: hold only
    step(0, 1,1,0, 1,5,5,0,0, C_HOLD, 0);
    step(0, 0,1,1, 0,0,0,0,0, C_NORM, 0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // reset during FLUSH and during MEM_WAIT drops the pending work
    step(0, 1,0,0, 0,0,0,0,0, C_JMP,  0);
    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);
    // timeout after four wait cycles; ERROR is sticky until reset
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    for (int i = 0; i < 4; i++) step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 0);
    step(0, 0,1,0, 0,0,0,0,0, C_HOLD, 1);
    step(0, 0,0,1, 0,0,0,0,0, C_HOLD, 1);
    step(0, 1,1,1, 1,5,5,0,0, C_HOLD, 1);
    step(1, 0,0,0, 0,0,0,0,0, C_RST,  0);
    step(0, 0,0,0, 0,0,0,0,0, C_NORM, 0);

    repeat (3) @(posedge CLK);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1; extra cycles IF_ID_FLUSH is held after a taken jump (range 0..7).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255; maximum DMEM wait cycles before error (range 1..255).
REQ-003 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ID_REG_RA1 / ID_REG_RA2  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port ID_UsesRA2  in  1  ID instruction reads RA2.
REQ-007 SHALL have port EX_MemRead  in  1  EX instruction is a load.
REQ-008 SHALL have port EX_REG_WA  in  5  EX destination register.
REQ-009 SHALL have port EX_JumpTaken  in  1  EX resolved a taken jump/branch this cycle.
REQ-010 SHALL have port DMEM_REQ  in  1  M stage is accessing data memory.
REQ-011 SHALL have port DMEM_READY  in  1  data memory completes the access this cycle.
REQ-012 SHALL have port PC_WE  out  1  PC update enable.
REQ-013 SHALL have port IF_ID_WE  out  1  IF/ID register enable.
REQ-014 SHALL have port IF_ID_FLUSH  out  1  IF/ID register loads a NOP.
REQ-015 SHALL have port ID_EX_BUBBLE  out  1  ID/EX register loads a NOP.
REQ-016 SHALL have port PIPE_HOLD  out  1  freeze ID/EX, EX/M and M/WB registers.
REQ-017 SHALL have port MEM_ERR  out  1  sticky timeout flag.
REQ-018 SHALL have port STALL_CNT  out  16  count of cycles with PC_WE=0.

Function
REQ-019 SHALL implement a four-state FSM: RUN, FLUSH, MEM_WAIT, ERROR.
REQ-020 SHALL define mem_stall = DMEM_REQ & ~DMEM_READY.
REQ-021 SHALL define load_use = EX_MemRead & (EX_REG_WA!=0) & ((EX_REG_WA==ID_REG_RA1) | (ID_UsesRA2 & EX_REG_WA==ID_REG_RA2)).
REQ-022 SHALL apply priority mem_stall > EX_JumpTaken > load_use, evaluated every cycle in RUN and FLUSH.
REQ-023 SHALL, on mem_stall in RUN/FLUSH: drive PC_WE=0, IF_ID_WE=0, PIPE_HOLD=1 in that same cycle; save the current state and flush counter; go to MEM_WAIT.
REQ-024 SHALL, in MEM_WAIT: drive PC_WE=0, IF_ID_WE=0, PIPE_HOLD=1, and increment an 8-bit wait counter each cycle.
REQ-025 SHALL, in MEM_WAIT with DMEM_READY=1: release the hold in that cycle, clear the wait counter, and return to the saved state with the flush counter unchanged.
REQ-026 SHALL enter ERROR when the wait counter equals MEM_TIMEOUT with DMEM_READY=0.
REQ-027 SHALL, in ERROR: set MEM_ERR=1, drive PC_WE=0, IF_ID_WE=0, PIPE_HOLD=1, and leave only on RST.
REQ-028 SHALL, on EX_JumpTaken without mem_stall: drive PC_WE=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1 in that cycle.
REQ-029 SHALL, after REQ-028, load the flush counter with FLUSH_CYCLES and go to FLUSH if FLUSH_CYCLES>0, else stay in RUN.
REQ-030 SHALL, in FLUSH: drive IF_ID_FLUSH=1 and PC_WE=1, decrement the counter, and return to RUN when the counter reaches 0.
REQ-031 SHALL treat a new EX_JumpTaken during FLUSH as REQ-028 (counter reload).
REQ-032 SHALL, on load_use without mem_stall or jump: drive PC_WE=0, IF_ID_WE=0, ID_EX_BUBBLE=1 for one cycle and stay in the current state.
REQ-033 SHALL, when no condition is active: drive PC_WE=1, IF_ID_WE=1, and all other controls 0.
REQ-034 SHALL increment STALL_CNT on every cycle with PC_WE=0, saturating at 0xFFFF.

Reset
REQ-035 SHALL, on RST=1 at a clock edge: set state=RUN, clear all counters and the saved state, set MEM_ERR=0 and STALL_CNT=0.
REQ-036 SHALL, during RST=1: drive PC_WE=0, IF_ID_WE=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PIPE_HOLD=0.
REQ-037 SHALL, if RST asserts mid-MEM_WAIT or mid-FLUSH, discard the pending operation.

Structure
REQ-038 SHALL place the FSM state encoding (2-bit) and the default FLUSH_CYCLES and MEM_TIMEOUT constants in the shared pipeline package.
REQ-039 SHALL implement the 16-bit saturating counter as sub-module sat_counter.

Verification
REQ-040 SHALL cover: load x5 in EX, ID reads RA1=x5 -> one cycle with PC_WE=0, ID_EX_BUBBLE=1, then normal flow; same case with RA1=x0 -> no stall.
REQ-041 SHALL cover: EX_JumpTaken with FLUSH_CYCLES=1 -> IF_ID_FLUSH=1 for 2 cycles, PC_WE=1 throughout.
REQ-042 SHALL cover: DMEM_REQ=1 with READY low 3 cycles -> PIPE_HOLD=1 for 3 cycles, release on READY, STALL_CNT=3.
REQ-043 SHALL cover: mem_stall during FLUSH with count 1 -> after READY, exactly 1 more flush cycle.
REQ-044 SHALL cover: READY held low with MEM_TIMEOUT=4 -> ERROR and MEM_ERR=1 after 4 wait cycles, held until RST.
REQ-045 SHALL cover: simultaneous mem_stall, jump and load_use -> hold only, no flush, no bubble.
